// File: rtl/alu_muldiv_mc_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: operation
// encodings, FSM states and a small decode helper.
package alu_muldiv_mc_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_t;

    function automatic logic is_signed_op(input mdu_op_t op_i);
        return (op_i == MDU_MULT) || (op_i == MDU_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_mc_div_radix2_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per clock, WIDTH
// iterations after load. finish marks the clock edge doing the last iteration.
module div_radix2_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             finish
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;

    // Partial remainder always stays below the divisor, so one extra bit suffices.
    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_ge    = ~w_diff[WIDTH];
    assign finish  = r_run && (r_cnt == CNT_W'(WIDTH - 1));
    assign quot    = r_quot;
    assign rem     = r_rem;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
        end else if (load) begin
            r_rem  <= '0;
            r_quot <= dividend;
            r_div  <= divisor;
            r_cnt  <= '0;
            r_run  <= 1'b1;
        end else if (r_run) begin
            r_rem  <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quot <= {r_quot[WIDTH-2:0], w_ge};
            r_cnt  <= r_cnt + 1'b1;
            if (finish) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_mc.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit writing HI/LO. Pipelined multiplier,
// iterative unsigned divider with sign restoration in a final FIX cycle.
module alu_muldiv_mc
    import alu_muldiv_mc_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(MUL_LATENCY + 1);

    mdu_state_t       r_state;
    mdu_state_t       w_state_next;
    mdu_op_t          r_op;
    mdu_op_t          w_op_in;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_dz;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_mul_fire;
    logic             w_fix_fire;
    logic             w_div_load;
    logic             w_div_finish;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;
    logic             w_neg_q;
    logic             w_neg_r;

    assign w_op_in = mdu_op_t'(op);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_mul_fire   = 1'b0;
        w_fix_fire   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (!op[1]) begin
                        w_state_next = ST_MUL;
                    end else if (b == '0) begin
                        w_state_next = ST_FIX;
                    end else begin
                        w_state_next = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                if (r_cnt == CNT_W'(MUL_LATENCY - 1)) begin
                    w_mul_fire   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (w_div_finish) begin
                    w_state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_fix_fire   = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        // Flush overrides everything, including a start in the same cycle.
        if (flush) begin
            w_state_next = ST_IDLE;
            w_accept     = 1'b0;
            w_mul_fire   = 1'b0;
            w_fix_fire   = 1'b0;
        end
    end

    // ---------------- multiplier ----------------
    // Operands sign/zero-extended to 2W bits; the low 2W product bits equal
    // the (W+1)x(W+1) signed product, which covers both MULT and MULTU.
    logic [2*WIDTH-1:0] w_a_sx;
    logic [2*WIDTH-1:0] w_b_sx;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mul_out;

    assign w_a_sx = {{WIDTH{is_signed_op(r_op) & r_a[WIDTH-1]}}, r_a};
    assign w_b_sx = {{WIDTH{is_signed_op(r_op) & r_b[WIDTH-1]}}, r_b};
    assign w_prod = w_a_sx * w_b_sx;

    generate
        if (MUL_LATENCY == 1) begin : g_mul_nopipe
            assign w_mul_out = w_prod;
        end else begin : g_mul_pipe
            logic [2*WIDTH-1:0] r_pipe [MUL_LATENCY-1];
            always_ff @(posedge clk) begin
                r_pipe[0] <= w_prod;
                for (int i = 1; i < MUL_LATENCY - 1; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign w_mul_out = r_pipe[MUL_LATENCY-2];
        end
    endgenerate

    // ---------------- divider ----------------
    assign w_div_load = w_accept && op[1] && (b != '0);
    assign w_dvd_mag  = ((w_op_in == MDU_DIV) && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_dvs_mag  = ((w_op_in == MDU_DIV) && b[WIDTH-1]) ? (~b + 1'b1) : b;

    div_radix2_core #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk      (clk),
        .srst     (rst),
        .load     (w_div_load),
        .dividend (w_dvd_mag),
        .divisor  (w_dvs_mag),
        .quot     (w_quot),
        .rem      (w_rem),
        .finish   (w_div_finish)
    );

    // Quotient negative when signs differ; remainder follows the dividend.
    assign w_neg_q  = is_signed_op(r_op) && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
    assign w_neg_r  = is_signed_op(r_op) && r_a[WIDTH-1];
    assign w_fix_lo = r_dz ? '1  : (w_neg_q ? (~w_quot + 1'b1) : w_quot);
    assign w_fix_hi = r_dz ? r_a : (w_neg_r ? (~w_rem + 1'b1) : w_rem);

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= MDU_MULT;
            r_a    <= '0;
            r_b    <= '0;
            r_dz   <= 1'b0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= w_mul_fire | w_fix_fire;
            if (w_accept) begin
                r_op  <= w_op_in;
                r_a   <= a;
                r_b   <= b;
                r_dz  <= (b == '0);
                r_cnt <= '0;
            end else if (r_state == ST_MUL) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_mul_fire) begin
                r_hi <= w_mul_out[2*WIDTH-1:WIDTH];
                r_lo <= w_mul_out[WIDTH-1:0];
            end else if (w_fix_fire) begin
                r_hi <= w_fix_hi;
                r_lo <= w_fix_lo;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_alu_muldiv_mc.sv
// Bench for alu_muldiv_mc: vector table plus hand-written corner sequences;
// a scoreboard queue holds expected results until the done pulse appears.
module tb_alu_muldiv_mc;
    import alu_muldiv_mc_pkg::*;

    localparam int W  = 32;
    localparam int ML = 2;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         flush = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'd0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    alu_muldiv_mc #(.WIDTH(W), .MUL_LATENCY(ML)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n_done = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
        int           t;
        string        name;
    } exp_t;

    exp_t sb[$];
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: one line per completed transaction.
    exp_t m_e;
    always begin
        @(posedge clk);
        #1;
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=done hi=%h lo=%h required=no done", hi, lo);
            end else begin
                m_e = sb.pop_front();
                chk({m_e.name, "_hi"}, hi, m_e.hi);
                chk({m_e.name, "_lo"}, lo, m_e.lo);
                chk({m_e.name, "_latency"}, W'(cyc - m_e.t), W'(m_e.lat));
                last_hi = m_e.hi;
                last_lo = m_e.lo;
                $display("txn %s hi=%h lo=%h latency=%0d", m_e.name, hi, lo, cyc - m_e.t);
            end
        end
    end

    // Reference model, independent of the RTL structure.
    function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, q, r;
        logic [2*W-1:0] p;
        logic [W-1:0] ones;
        ones = '1;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: p = sx * sy;
            2'd1: p = {32'b0, x} * {32'b0, y};
            2'd2: begin
                if (y == '0) p = {x, ones};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[W-1:0], q[W-1:0]};
                end
            end
            default: begin
                if (y == '0) p = {x, ones};
                else p = {x % y, x / y};
            end
        endcase
        return p;
    endfunction

    // Drive a start (called #1 after an edge) and expect acceptance.
    task automatic issue(input string name, input logic [1:0] o, input logic [W-1:0] xa,
                         input logic [W-1:0] xb, input logic [W-1:0] xhi,
                         input logic [W-1:0] xlo, input int lat);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = xa;
        b     = xb;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, "_accept_busy"}, W'(busy), W'(1));
        e.hi = xhi; e.lo = xlo; e.lat = lat; e.t = cyc; e.name = name;
        sb.push_back(e);
        n_acc++;
    endtask

    task automatic wait_done(input string name, input int lat, input int bc0);
        int  bc;
        bit  got;
        bc  = bc0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) bc++;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=no done required=done", name);
        end else begin
            chk({name, "_busy_cycles"}, W'(bc), W'(lat));
            chk({name, "_busy_at_done"}, W'(busy), W'(0));
        end
    endtask

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [2*W-1:0] p;
        logic [1:0]     ro;
        logic [W-1:0]   ra, rb;
        int             rl;

        vecs[0]  = '{"mult_neg2x3",   2'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, ML};
        vecs[1]  = '{"multu_max",     2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, ML};
        vecs[2]  = '{"div_m7_2",      2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, W+1};
        vecs[3]  = '{"divu_m7_2",     2'd3, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, W+1};
        vecs[4]  = '{"div_min_m1",    2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, W+1};
        vecs[5]  = '{"divu_5_0",      2'd3, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1};
        vecs[6]  = '{"div_7_m2",      2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, W+1};
        vecs[7]  = '{"mult_min_min",  2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, ML};
        vecs[8]  = '{"div_m7_0",      2'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1};
        vecs[9]  = '{"multu_zero",    2'd1, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, ML};
        vecs[10] = '{"divu_100_7",    2'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, W+1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_done", W'(done), W'(0));
        chk("reset_hi", hi, '0);
        chk("reset_lo", lo, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat);
            wait_done(vecs[i].name, vecs[i].lat, 1);
        end

        // Random operations against the model
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 5) ? '0 : $urandom;
            if (i == 6) rb = 32'($urandom_range(1, 9));
            p  = model(ro, ra, rb);
            rl = ro[1] ? ((rb == '0) ? 1 : W + 1) : ML;
            issue($sformatf("rand%0d", i), ro, ra, rb, p[2*W-1:W], p[W-1:0], rl);
            wait_done($sformatf("rand%0d", i), rl, 1);
        end

        // Back-to-back: second start in the done cycle of a MULT
        issue("b2b_mult", 2'd0, 32'd3, 32'd5, 32'd0, 32'd15, ML);
        wait_done("b2b_mult", ML, 1);
        issue("b2b_multu", 2'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, ML);
        wait_done("b2b_multu", ML, 1);

        // Start while busy is ignored
        issue("ign_div", 2'd3, 32'd1000, 32'd10, 32'd0, 32'd100, W+1);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ign_div", W+1, 6);
        repeat (6) @(posedge clk);
        #1;

        // Flush mid-DIV: no done, hi/lo retained
        issue("flush_div", 2'd3, 32'd100, 32'd3, 32'd0, 32'd0, W+1);
        void'(sb.pop_back());
        n_acc--;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", W'(busy), W'(0));
        chk("flush_hi", hi, last_hi);
        chk("flush_lo", lo, last_lo);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_after_hi", hi, last_hi);
        chk("flush_after_lo", lo, last_lo);

        // Start and flush together: dropped
        start = 1'b1; flush = 1'b1; op = 2'd2; a = 32'd50; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("startflush_busy", W'(busy), W'(0));
        repeat (40) @(posedge clk);
        #1;
        chk("startflush_hi", hi, last_hi);

        // Reset mid-DIV
        issue("rst_div", 2'd2, 32'd12345, 32'd17, 32'd0, 32'd0, W+1);
        void'(sb.pop_back());
        n_acc--;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        last_hi = '0;
        last_lo = '0;
        repeat (40) @(posedge clk);
        #1;
        issue("post_rst_mult", 2'd0, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, ML);
        wait_done("post_rst_mult", ML, 1);
        repeat (3) @(posedge clk);
        #1;

        chk("done_count", W'(n_done), W'(n_acc));
        chk("scoreboard_empty", W'(sb.size()), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
